// File: rtl/mode_sequencer_if.sv
// Interface bundling the button/timebase inputs and the mode/countdown/run
// status outputs of mode_sequencer. The master side drives the inputs; the
// slave side is the sequencer itself.
interface mode_sequencer_if #(
    parameter int unsigned TIME_W = 8
);
    logic [3:0]        buttons_i;
    logic              tick_i;
    logic              game_over_i;
    logic [1:0]        mode_o;
    logic [2:0]        state_o;
    logic [3:0]        countdown_o;
    logic [TIME_W-1:0] time_left_o;
    logic              countdown_start_o;
    logic              run_start_o;
    logic              run_o;
    logic              done_o;

    modport master (
        output buttons_i, tick_i, game_over_i,
        input  mode_o, state_o, countdown_o, time_left_o,
               countdown_start_o, run_start_o, run_o, done_o
    );

    modport slave (
        input  buttons_i, tick_i, game_over_i,
        output mode_o, state_o, countdown_o, time_left_o,
               countdown_start_o, run_start_o, run_o, done_o
    );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer: game-flow controller. Synchronises the four menu buttons,
// latches the chosen mode, runs a pre-game countdown and a timed run phase,
// then holds the result until a new mode is chosen or the menu button aborts.
// Optional feature macro: MODE_SEQ_PAUSE_EN (button [0] toggles RUN <-> PAUSE).
module mode_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned COUNTDOWN_LEN = 3,
    parameter int unsigned RUN_LEN       = 30,
    parameter int unsigned TIME_W        = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mode_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_DONE      = 3'd3,
        S_PAUSE     = 3'd4
    } state_t;

    logic [3:0]        sync_q [SYNC_STAGES];
    logic [3:0]        btn_prev_q;
    logic [3:0]        edge_q;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              cd_start_q, cd_start_d;
    logic              run_start_q, run_start_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    logic              abort_edge;
    logic              mode_edge;
    logic [1:0]        sel_mode;
    logic              pause_req;

    // Button synchroniser chain followed by a registered rising-edge detector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            btn_prev_q <= '0;
            edge_q     <= '0;
        end else begin
            sync_q[0] <= bus.buttons_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            btn_prev_q <= sync_q[SYNC_STAGES-1];
            edge_q     <= sync_q[SYNC_STAGES-1] & ~btn_prev_q;
        end
    end

    // Edge priority decode: [3] abort beats mode buttons, [2] > [1] > [0]
    always_comb begin
        abort_edge = edge_q[3];
        mode_edge  = (|edge_q[2:0]) & ~edge_q[3];
        if (edge_q[2]) begin
            sel_mode = 2'b01;
        end else if (edge_q[1]) begin
            sel_mode = 2'b10;
        end else begin
            sel_mode = 2'b11;
        end
`ifdef MODE_SEQ_PAUSE_EN
        pause_req = edge_q[0] & ~(|edge_q[3:1]);
`else
        pause_req = 1'b0;
`endif
    end

    // State register plus registered datapath and outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            time_q      <= '0;
            cd_start_q  <= 1'b0;
            run_start_q <= 1'b0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            time_q      <= time_d;
            cd_start_q  <= cd_start_d;
            run_start_q <= run_start_d;
            run_q       <= run_d;
            done_q      <= done_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        if (abort_edge) begin
            state_d = S_IDLE;
            mode_d  = '0;
            cnt_d   = '0;
            time_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (mode_edge) begin
                        mode_d = sel_mode;
                        if (COUNTDOWN_LEN == 0) begin
                            state_d = S_RUN;
                            time_d  = TIME_W'(RUN_LEN);
                        end else begin
                            state_d = S_COUNTDOWN;
                            cnt_d   = 4'(COUNTDOWN_LEN);
                        end
                    end
                end
                S_COUNTDOWN: begin
                    // A zero count here can only come from corruption; treat it
                    // like the final tick so the countdown cannot stall.
                    if (bus.tick_i) begin
                        if (cnt_q <= 4'd1) begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            time_d  = TIME_W'(RUN_LEN);
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    // Pause request wins over game_over/tick in the same cycle
                    if (pause_req) begin
                        state_d = S_PAUSE;
                    end else if (bus.game_over_i) begin
                        state_d = S_DONE;
                    end else if (bus.tick_i) begin
                        if (time_q <= TIME_W'(1)) begin
                            state_d = S_DONE;
                            time_d  = '0;
                        end else begin
                            time_d = time_q - TIME_W'(1);
                        end
                    end
                end
`ifdef MODE_SEQ_PAUSE_EN
                S_PAUSE: begin
                    if (pause_req) begin
                        state_d = S_RUN;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    mode_d  = '0;
                    cnt_d   = '0;
                    time_d  = '0;
                end
            endcase
        end
    end

    // Registered output decode; resuming from PAUSE is not a new run start
    always_comb begin
        cd_start_d  = (state_d == S_COUNTDOWN) && (state_q != S_COUNTDOWN);
        run_start_d = (state_d == S_RUN) && (state_q != S_RUN) && (state_q != S_PAUSE);
        run_d       = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    assign bus.mode_o            = mode_q;
    assign bus.state_o           = state_q;
    assign bus.countdown_o       = cnt_q;
    assign bus.time_left_o       = time_q;
    assign bus.countdown_start_o = cd_start_q;
    assign bus.run_start_o       = run_start_q;
    assign bus.run_o             = run_q;
    assign bus.done_o            = done_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed testbench for mode_sequencer (SYNC_STAGES=2, COUNTDOWN_LEN=3,
// RUN_LEN=30, TIME_W=8). Honours MODE_SEQ_PAUSE_EN for the pause scenario.
module tb_mode_sequencer;

    logic clk;
    logic rst_ni;
    int   n_cmp;
    int   n_fail;
    int   pulses;

    mode_sequencer_if #(.TIME_W(8)) bus ();

    mode_sequencer #(
        .SYNC_STAGES  (2),
        .COUNTDOWN_LEN(3),
        .RUN_LEN      (30),
        .TIME_W       (8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_i = 1'b1;
            cyc(1);
        end
        bus.tick_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(bus.state_o), 32'd0);
        chk({tag, "_mode"},  32'(bus.mode_o), 32'd0);
        chk({tag, "_cd"},    32'(bus.countdown_o), 32'd0);
        chk({tag, "_time"},  32'(bus.time_left_o), 32'd0);
        chk({tag, "_cds"},   32'(bus.countdown_start_o), 32'd0);
        chk({tag, "_rs"},    32'(bus.run_start_o), 32'd0);
        chk({tag, "_run"},   32'(bus.run_o), 32'd0);
        chk({tag, "_done"},  32'(bus.done_o), 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.buttons_i   = 4'b0000;
        bus.tick_i      = 1'b0;
        bus.game_over_i = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Mode 2 from IDLE: 3 edges to the edge pulse, state changes on the 4th
        bus.buttons_i = 4'b0010;
        cyc(3);
        chk("pre_entry_state", 32'(bus.state_o), 32'd0);
        cyc(1);
        chk("m2_state", 32'(bus.state_o), 32'd1);
        chk("m2_mode",  32'(bus.mode_o), 32'b10);
        chk("m2_cd",    32'(bus.countdown_o), 32'd3);
        chk("m2_cds",   32'(bus.countdown_start_o), 32'd1);
        cyc(1);
        chk("m2_cds_off", 32'(bus.countdown_start_o), 32'd0);
        bus.buttons_i = 4'b0000;
        tick_n(1);
        chk("cd_2", 32'(bus.countdown_o), 32'd2);
        tick_n(1);
        chk("cd_1", 32'(bus.countdown_o), 32'd1);
        tick_n(1);
        chk("run_state", 32'(bus.state_o), 32'd2);
        chk("run_start", 32'(bus.run_start_o), 32'd1);
        chk("run_time",  32'(bus.time_left_o), 32'd30);
        chk("run_cd0",   32'(bus.countdown_o), 32'd0);
        chk("run_o",     32'(bus.run_o), 32'd1);
        cyc(1);
        chk("run_start_off", 32'(bus.run_start_o), 32'd0);
        tick_n(29);
        chk("time_1",       32'(bus.time_left_o), 32'd1);
        chk("time_1_state", 32'(bus.state_o), 32'd2);
        tick_n(1);
        chk("timeout_state", 32'(bus.state_o), 32'd3);
        chk("timeout_time",  32'(bus.time_left_o), 32'd0);
        chk("timeout_done",  32'(bus.done_o), 32'd1);
        chk("timeout_run",   32'(bus.run_o), 32'd0);
        chk("timeout_mode",  32'(bus.mode_o), 32'b10);

        // DONE + [0]: new mode 3, countdown restarts
        bus.buttons_i = 4'b0001;
        cyc(4);
        bus.buttons_i = 4'b0000;
        chk("m3_state", 32'(bus.state_o), 32'd1);
        chk("m3_mode",  32'(bus.mode_o), 32'b11);
        chk("m3_cds",   32'(bus.countdown_start_o), 32'd1);
        chk("m3_cd",    32'(bus.countdown_o), 32'd3);
        tick_n(1);
        chk("m3_cd2",   32'(bus.countdown_o), 32'd2);

        // Abort in COUNTDOWN with a tick on the same cycle
        bus.buttons_i = 4'b1000;
        cyc(3);
        chk("abort_cd_pre", 32'(bus.countdown_o), 32'd2);
        bus.tick_i = 1'b1;
        cyc(1);
        bus.tick_i = 1'b0;
        chk("abort_cd_state", 32'(bus.state_o), 32'd0);
        chk("abort_cd_mode",  32'(bus.mode_o), 32'd0);
        chk("abort_cd_cd",    32'(bus.countdown_o), 32'd0);
        bus.buttons_i = 4'b0000;
        cyc(2);

        // [2] and [0] together, held 100 cycles: mode 1, one start pulse
        bus.buttons_i = 4'b0101;
        cyc(4);
        chk("both_mode", 32'(bus.mode_o), 32'b01);
        chk("both_cds",  32'(bus.countdown_start_o), 32'd1);
        pulses = 0;
        for (int i = 0; i < 96; i++) begin
            cyc(1);
            if (bus.countdown_start_o === 1'b1) pulses++;
        end
        chk("held_pulses", 32'(pulses), 32'd0);
        chk("held_state",  32'(bus.state_o), 32'd1);
        chk("held_cd",     32'(bus.countdown_o), 32'd3);
        bus.buttons_i = 4'b0000;
        tick_n(3);
        chk("run2_time", 32'(bus.time_left_o), 32'd30);
        tick_n(18);
        chk("run2_t12", 32'(bus.time_left_o), 32'd12);
        bus.game_over_i = 1'b1;
        bus.tick_i      = 1'b1;
        cyc(1);
        bus.tick_i = 1'b0;
        chk("go_state", 32'(bus.state_o), 32'd3);
        chk("go_time",  32'(bus.time_left_o), 32'd12);
        chk("go_done",  32'(bus.done_o), 32'd1);
        tick_n(3);
        chk("done_hold_state", 32'(bus.state_o), 32'd3);
        chk("done_hold_time",  32'(bus.time_left_o), 32'd12);
        bus.game_over_i = 1'b0;

        // DONE + [1] -> RUN, then [0] in RUN at time 20
        bus.buttons_i = 4'b0010;
        cyc(4);
        bus.buttons_i = 4'b0000;
        chk("m2b_mode", 32'(bus.mode_o), 32'b10);
        tick_n(3);
        tick_n(10);
        chk("run3_t20", 32'(bus.time_left_o), 32'd20);
        bus.buttons_i = 4'b0001;
        cyc(4);
        bus.buttons_i = 4'b0000;
`ifdef MODE_SEQ_PAUSE_EN
        chk("pause_state", 32'(bus.state_o), 32'd4);
        chk("pause_run",   32'(bus.run_o), 32'd0);
        tick_n(5);
        chk("pause_time",  32'(bus.time_left_o), 32'd20);
        chk("pause_hold",  32'(bus.state_o), 32'd4);
        bus.buttons_i = 4'b0001;
        cyc(4);
        bus.buttons_i = 4'b0000;
        chk("resume_state", 32'(bus.state_o), 32'd2);
        chk("resume_run",   32'(bus.run_o), 32'd1);
`else
        chk("b0_run_state", 32'(bus.state_o), 32'd2);
        chk("b0_run_o",     32'(bus.run_o), 32'd1);
        chk("b0_run_mode",  32'(bus.mode_o), 32'b10);
`endif
        chk("b0_time20", 32'(bus.time_left_o), 32'd20);
        tick_n(1);
        chk("time19", 32'(bus.time_left_o), 32'd19);

        // Abort in RUN with a tick on the same cycle
        bus.buttons_i = 4'b1000;
        cyc(3);
        chk("abort_run_pre", 32'(bus.state_o), 32'd2);
        bus.tick_i = 1'b1;
        cyc(1);
        bus.tick_i = 1'b0;
        chk("abort_run_state", 32'(bus.state_o), 32'd0);
        chk("abort_run_mode",  32'(bus.mode_o), 32'd0);
        chk("abort_run_time",  32'(bus.time_left_o), 32'd0);
        chk("abort_run_run",   32'(bus.run_o), 32'd0);
        bus.buttons_i = 4'b0000;
        cyc(2);

        // Ticks in IDLE do nothing
        tick_n(2);
        chk("idle_tick_state", 32'(bus.state_o), 32'd0);
        chk("idle_tick_cd",    32'(bus.countdown_o), 32'd0);

        // Asynchronous reset in the middle of RUN
        bus.buttons_i = 4'b0100;
        cyc(4);
        bus.buttons_i = 4'b0000;
        chk("m1_mode", 32'(bus.mode_o), 32'b01);
        tick_n(3);
        chk("m1_run", 32'(bus.state_o), 32'd2);
        #3 rst_ni = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2 rst_ni = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
